// File: rtl/rf_wb_queue_pkg.sv
// Register-file geometry shared with the cpu_2432 core, plus the write-back entry layout.
package rf_wb_queue_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;
  localparam int RF_WEN_W  = 4;
  localparam int RF_NREGS  = 1 << RF_ADDR_W;

  localparam logic [RF_WEN_W-1:0] WEN_FULL = 4'hF;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_WEN_W-1:0]  wen;
    logic [RF_DATA_W-1:0] din;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Storage and pointers for the write-back queue; exposes contents in age order (index 0 = head).
module wbq_fifo
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_b,
  input  logic                  i_push,
  input  wb_entry_t             i_push_entry,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output wb_entry_t [DEPTH-1:0] o_ord_entries,
  output logic [DEPTH-1:0]      o_ord_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (i_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: every consumer masks it with the occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_ord_entries[i] = mem[rd_ptr + PTR_W'(i)];
      o_ord_valid[i]   = (CNT_W'(i) < count);
    end
  end

  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);

endmodule

// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: load/ALU arbitration, busy mask and optional operand forwarding.
// Forwarding is compiled in only when the macro RF_WB_FWD_EN is defined.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_b,
  input  logic                 i_clk_en,
  input  logic                 i_alu_valid,
  input  logic [RF_ADDR_W-1:0] i_alu_waddr,
  input  logic [RF_DATA_W-1:0] i_alu_din,
  output logic                 o_alu_ready,
  input  logic                 i_ld_valid,
  input  logic [RF_ADDR_W-1:0] i_ld_waddr,
  input  logic [RF_WEN_W-1:0]  i_ld_wen,
  input  logic [RF_DATA_W-1:0] i_ld_din,
  output logic                 o_ld_ready,
  output logic [RF_ADDR_W-1:0] o_rf_waddr,
  output logic [RF_WEN_W-1:0]  o_rf_wen,
  output logic [RF_DATA_W-1:0] o_rf_din,
  output logic                 o_rf_cs_b,
  output logic [RF_NREGS-1:0]  o_busy,
  input  logic [RF_ADDR_W-1:0] i_raddr_0,
  input  logic [RF_ADDR_W-1:0] i_raddr_1,
  output logic                 o_fwd_hit_0,
  output logic                 o_fwd_hit_1,
  output logic [RF_DATA_W-1:0] o_fwd_dout_0,
  output logic [RF_DATA_W-1:0] o_fwd_dout_1
);

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  ld_fire;
  logic                  alu_fire;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] ord_entries;
  logic [DEPTH-1:0]      ord_valid;

  // Readiness looks only at current occupancy, so a full queue refuses even on a popping edge.
  assign o_ld_ready  = i_clk_en & ~full;
  assign o_alu_ready = i_clk_en & ~full & ~i_ld_valid;
  assign ld_fire     = i_ld_valid & o_ld_ready;
  assign alu_fire    = i_alu_valid & o_alu_ready;

  // A load with no byte enables is handshaken but never occupies a slot.
  assign push = (ld_fire & (i_ld_wen != '0)) | alu_fire;
  assign pop  = i_clk_en & ~empty;

  always_comb begin
    if (ld_fire) begin
      push_entry = '{waddr: i_ld_waddr, wen: i_ld_wen, din: i_ld_din};
    end else begin
      push_entry = '{waddr: i_alu_waddr, wen: WEN_FULL, din: i_alu_din};
    end
  end

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk         (i_clk),
    .i_rst_b       (i_rst_b),
    .i_push        (push),
    .i_push_entry  (push_entry),
    .i_pop         (pop),
    .o_full        (full),
    .o_empty       (empty),
    .o_ord_entries (ord_entries),
    .o_ord_valid   (ord_valid)
  );

  assign head       = empty ? '0 : ord_entries[0];
  assign o_rf_waddr = head.waddr;
  assign o_rf_wen   = head.wen;
  assign o_rf_din   = head.din;
  assign o_rf_cs_b  = empty;

  always_comb begin
    o_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_valid[i]) o_busy[ord_entries[i].waddr] = 1'b1;
    end
  end

`ifdef RF_WB_FWD_EN
  // Youngest match wins; a partial-enable youngest entry cannot supply a full word.
  function automatic logic [RF_DATA_W:0] fwd_lookup(
    input logic [RF_ADDR_W-1:0] raddr,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [DEPTH-1:0]      vld
  );
    logic      found;
    wb_entry_t youngest;
    found    = 1'b0;
    youngest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ents[i].waddr == raddr)) begin
        found    = 1'b1;
        youngest = ents[i];
      end
    end
    if (found && (youngest.wen == WEN_FULL)) return {1'b1, youngest.din};
    return '0;
  endfunction

  assign {o_fwd_hit_0, o_fwd_dout_0} = fwd_lookup(i_raddr_0, ord_entries, ord_valid);
  assign {o_fwd_hit_1, o_fwd_dout_1} = fwd_lookup(i_raddr_1, ord_entries, ord_valid);
`else
  logic unused_raddr;
  assign unused_raddr = ^{i_raddr_0, i_raddr_1};
  assign o_fwd_hit_0  = 1'b0;
  assign o_fwd_hit_1  = 1'b0;
  assign o_fwd_dout_0 = '0;
  assign o_fwd_dout_1 = '0;
`endif

endmodule
